aq_mmu_jtlb_data_ram_ctrl: RTL

Parametrised JTLB data storage for the MMU: a single-port, way-banked data array with per-way write enables, per-way parity, a registered read port with valid handshake, and a hardware sweep FSM that zero-initialises every entry after reset and on a flush request. It sits between the JTLB lookup/refill logic and the physical storage. It generalises the fixed 64-entry, 2×44-bit data array to arbitrary depth, way count and way width. The array clock is gated with the standard `gated_clk_cell`.

---
 rtl/aq_mmu_jtlb_data_ram_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/aq_mmu_jtlb_data_ram_ctrl.sv
// JTLB data array controller: way-banked storage with per-way parity, a registered
// read port and a zero-fill sweep that runs after reset and on flush requests.
module aq_mmu_jtlb_data_ram_ctrl #(
    parameter int WAYS      = 2,
    parameter int WAY_WIDTH = 44,
    parameter int DEPTH     = 64,
    parameter int ADDR_W    = 6
) (
    input  logic                      forever_cpuclk,
    input  logic                      cpurst_b,
    input  logic                      cp0_mmu_icg_en,
    input  logic                      pad_yy_icg_scan_en,
    input  logic                      req_vld,
    output logic                      req_rdy,
    input  logic [ADDR_W-1:0]         req_idx,
    input  logic [WAYS-1:0]           req_wen,
    input  logic [WAYS*WAY_WIDTH-1:0] req_din,
    input  logic                      req_perr_inj,
    output logic                      rd_vld,
    output logic [WAYS*WAY_WIDTH-1:0] rd_dout,
    output logic [WAYS-1:0]           rd_perr,
    input  logic                      flush_req,
    output logic                      flush_busy,
    output logic                      flush_done
);

    typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   cnt_reg, cnt_next;
    logic                done_reg, done_next;
    logic                rd_vld_reg;
    logic                sweep_act;
    logic                req_acc;
    logic                rd_acc;
    logic                wr_acc;
    logic                local_en;
    logic                array_clk;

    // State register
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_reg <= SWEEP;
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
        end
    end

    // Next-state logic; the counter wraps to 0 naturally after DEPTH-1
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (flush_req) begin
                    state_next = SWEEP;
                    cnt_next   = '0;
                end
            end
            SWEEP: begin
                cnt_next = cnt_reg + 1'b1;
                if (cnt_reg == ADDR_W'(DEPTH - 1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = SWEEP;
                cnt_next   = '0;
            end
        endcase
    end

    // Output logic; a same-cycle flush wins over a request
    always_comb begin
        sweep_act  = (state_reg == SWEEP);
        req_rdy    = (state_reg == IDLE) && !flush_req;
        flush_busy = sweep_act;
        flush_done = done_reg;
        req_acc    = req_vld && req_rdy;
        rd_acc     = req_acc && (req_wen == '0);
        wr_acc     = req_acc && (req_wen != '0);
        local_en   = req_acc || sweep_act;
    end

    gated_clk_cell u_array_gclk (
        .clk_in             (forever_cpuclk),
        .global_en          (1'b1),
        .module_en          (cp0_mmu_icg_en),
        .local_en           (local_en),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (array_clk)
    );

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rd_vld_reg <= 1'b0;
        end else begin
            rd_vld_reg <= rd_acc;
        end
    end

    assign rd_vld = rd_vld_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            logic [WAY_WIDTH:0]   mem [DEPTH];
            logic [WAY_WIDTH-1:0] wr_data;
            logic [WAY_WIDTH:0]   wr_word;
            logic [WAY_WIDTH:0]   rd_word;
            logic [ADDR_W-1:0]    wr_addr;
            logic                 wr_en;
            logic [WAY_WIDTH-1:0] rd_data_reg;
            logic                 rd_perr_reg;

            // Word layout is {parity, data}; the sweep stores all-zero with parity 0
            assign wr_data = req_din[gi*WAY_WIDTH +: WAY_WIDTH];
            assign wr_en   = sweep_act || (wr_acc && req_wen[gi]);
            assign wr_addr = sweep_act ? cnt_reg : req_idx;
            assign wr_word = sweep_act ? '0 : {(^wr_data) ^ req_perr_inj, wr_data};
            assign rd_word = mem[req_idx];

            always_ff @(posedge array_clk) begin
                if (wr_en) begin
                    mem[wr_addr] <= wr_word;
                end
            end

            // XOR over data and stored parity is 1 exactly on a parity mismatch
            always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
                if (!cpurst_b) begin
                    rd_data_reg <= '0;
                    rd_perr_reg <= 1'b0;
                end else if (rd_acc) begin
                    rd_data_reg <= rd_word[WAY_WIDTH-1:0];
                    rd_perr_reg <= ^rd_word;
                end
            end

            assign rd_dout[gi*WAY_WIDTH +: WAY_WIDTH] = rd_data_reg;
            assign rd_perr[gi]                        = rd_perr_reg;
        end
    endgenerate

endmodule

// Clock gate: enable captured while the clock is low so the output never glitches.
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);

    logic clk_en_bf_latch;
    logic clk_en_reg;

    assign clk_en_bf_latch = (global_en && (module_en || local_en)) || external_en;

    always_ff @(negedge clk_in) begin
        clk_en_reg <= clk_en_bf_latch;
    end

    assign clk_out = clk_in && (clk_en_reg || pad_yy_icg_scan_en);

endmodule
